// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: load path normally wins, ALU path wins after
// STARVE_LIMIT consecutive losses; one registered register-file write per cycle.
module wb_port_arbiter #(
  parameter int XLEN         = 64,
  parameter int STARVE_LIMIT = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_result,
  output logic            alu_ready,
  input  logic            ld_valid,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            ld_ready,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  output logic            rf_src_ld,
  output logic [3:0]      starve_cnt
);

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  logic [3:0]      r_starve;
  logic            r_we;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_wdata;
  logic            r_src_ld;

  logic            w_force_alu;
  logic            w_ld_go;
  logic            w_alu_go;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_wdata;
  logic [3:0]      w_starve_nxt;

  assign w_force_alu = (r_starve == LIM);

  // Readies are held low while reset is asserted, so nothing can be accepted.
  always_comb begin
    w_ld_go  = 1'b0;
    w_alu_go = 1'b0;
    if (rst_n) begin
      w_ld_go  = ld_valid && !(alu_valid && w_force_alu);
      w_alu_go = alu_valid && (!ld_valid || w_force_alu);
    end
  end

  always_comb begin
    w_rd    = alu_rd;
    w_wdata = alu_result;
    if (w_ld_go) begin
      w_rd    = ld_rd;
      w_wdata = ld_data;
    end
  end

  always_comb begin
    w_starve_nxt = r_starve;
    if (w_alu_go || !alu_valid)
      w_starve_nxt = 4'd0;
    else if (w_ld_go && r_starve < LIM)
      w_starve_nxt = r_starve + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= 4'd0;
      r_we     <= 1'b0;
      r_rd     <= 5'd0;
      r_wdata  <= '0;
      r_src_ld <= 1'b0;
    end else begin
      r_starve <= w_starve_nxt;
      r_we     <= 1'b0;
      if (w_ld_go || w_alu_go) begin
        // x0 writes are accepted but never reach the register file
        r_we     <= (w_rd != 5'd0);
        r_rd     <= w_rd;
        r_wdata  <= w_wdata;
        r_src_ld <= w_ld_go;
      end
    end
  end

  assign ld_ready   = w_ld_go;
  assign alu_ready  = w_alu_go;
  assign rf_we      = r_we;
  assign rf_rd      = r_rd;
  assign rf_wdata   = r_wdata;
  assign rf_src_ld  = r_src_ld;
  assign starve_cnt = r_starve;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed scenarios plus random traffic
// checked against a cycle-level reference model.
module tb_wb_port_arbiter;

  localparam int XLEN = 64;
  localparam int LIM  = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            alu_valid = 1'b0;
  logic [4:0]      alu_rd = '0;
  logic [XLEN-1:0] alu_result = '0;
  logic            alu_ready;
  logic            ld_valid = 1'b0;
  logic [4:0]      ld_rd = '0;
  logic [XLEN-1:0] ld_data = '0;
  logic            ld_ready;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wdata;
  logic            rf_src_ld;
  logic [3:0]      starve_cnt;

  wb_port_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd),
    .alu_result(alu_result), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd),
    .ld_data(ld_data), .ld_ready(ld_ready),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .rf_src_ld(rf_src_ld), .starve_cnt(starve_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            we;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic            src;
  } wr_t;

  wr_t q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  m_starve = 0;
  wr_t m_hold = '0;

  task automatic chk(input string name, input logic [XLEN-1:0] act,
                     input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  wr_t mon_e;
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("rf_we", XLEN'(rf_we), XLEN'(mon_e.we));
      chk("rf_rd", XLEN'(rf_rd), XLEN'(mon_e.rd));
      chk("rf_wdata", rf_wdata, mon_e.data);
      chk("rf_src_ld", XLEN'(rf_src_ld), XLEN'(mon_e.src));
    end
  end

  // One cycle: drive, check same-cycle handshake against the model,
  // and queue the register-file outputs expected after the edge.
  task automatic cyc(input logic av, input logic [4:0] ard,
                     input logic [XLEN-1:0] ares, input logic lv,
                     input logic [4:0] lrd, input logic [XLEN-1:0] ldat,
                     output logic g_ld, output logic g_alu,
                     output logic [3:0] sc);
    bit e_ld, e_alu;
    wr_t e;
    @(posedge clk);
    #2;
    alu_valid = av; alu_rd = ard; alu_result = ares;
    ld_valid = lv; ld_rd = lrd; ld_data = ldat;
    @(negedge clk);
    e_ld  = lv && (!av || m_starve < LIM);
    e_alu = av && !e_ld;
    chk("ld_ready", XLEN'(ld_ready), XLEN'(e_ld));
    chk("alu_ready", XLEN'(alu_ready), XLEN'(e_alu));
    chk("starve_cnt", XLEN'(starve_cnt), XLEN'(m_starve));
    g_ld = ld_ready; g_alu = alu_ready; sc = starve_cnt;
    if (e_ld) begin
      m_hold.rd = lrd; m_hold.data = ldat; m_hold.src = 1'b1;
    end else if (e_alu) begin
      m_hold.rd = ard; m_hold.data = ares; m_hold.src = 1'b0;
    end
    e = m_hold;
    e.we = (e_ld || e_alu) && (m_hold.rd != 0);
    q.push_back(e);
    if (e_alu || !av) m_starve = 0;
    else if (lv && av) m_starve = m_starve + 1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_we"}, XLEN'(rf_we), '0);
    chk({tag, "_rd"}, XLEN'(rf_rd), '0);
    chk({tag, "_wdata"}, rf_wdata, '0);
    chk({tag, "_src"}, XLEN'(rf_src_ld), '0);
    chk({tag, "_starve"}, XLEN'(starve_cnt), '0);
    chk({tag, "_ldrdy"}, XLEN'(ld_ready), '0);
    chk({tag, "_alurdy"}, XLEN'(alu_ready), '0);
  endtask

  task automatic release_rst();
    alu_valid = 0; ld_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    m_starve = 0;
    m_hold = '0;
    q.push_back('0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic gl, ga;
  logic [3:0] sc;
  bit   exp_l[5] = '{1, 1, 1, 0, 1};
  int   exp_s[5] = '{0, 1, 2, 3, 0};

  initial begin
    #3;
    check_zero("reset");
    @(posedge clk);
    release_rst();

    // ALU only, rd=5, result=42
    cyc(1, 5, 42, 0, 0, 0, gl, ga, sc);
    chk("alu_only_rdy", XLEN'(ga), 1);
    cyc(0, 0, 0, 0, 0, 0, gl, ga, sc);
    chk("after_alu_we", XLEN'(rf_we), 1);
    chk("after_alu_rd", XLEN'(rf_rd), 5);
    chk("after_alu_data", rf_wdata, 42);

    // contention: L,L,L,A,L with starve 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      cyc(1, 5'(i + 1), XLEN'(100 + i), 1, 5'(i + 10), XLEN'(200 + i),
          gl, ga, sc);
      chk("starve_ld_grant", XLEN'(gl), XLEN'(exp_l[i]));
      chk("starve_seq", XLEN'(sc), XLEN'(exp_s[i]));
    end

    // load to x0 is accepted but suppressed
    cyc(0, 0, 0, 1, 0, 7, gl, ga, sc);
    chk("x0_ld_rdy", XLEN'(gl), 1);
    cyc(0, 0, 0, 0, 0, 0, gl, ga, sc);
    chk("x0_no_we", XLEN'(rf_we), 0);

    // alternating ALU/load back-to-back
    for (int i = 0; i < 8; i++) begin
      if (i[0]) cyc(0, 0, 0, 1, 5'(i + 1), XLEN'(i * 3), gl, ga, sc);
      else      cyc(1, 5'(i + 1), XLEN'(i * 5), 0, 0, 0, gl, ga, sc);
    end
    cyc(0, 0, 0, 0, 0, 0, gl, ga, sc);

    // ALU drops out while starve=2: count clears, load keeps winning
    cyc(1, 1, 1, 1, 2, 2, gl, ga, sc);
    cyc(1, 1, 1, 1, 2, 2, gl, ga, sc);
    cyc(0, 0, 0, 1, 3, 3, gl, ga, sc);
    chk("drop_prev_starve", XLEN'(sc), 2);
    cyc(0, 0, 0, 1, 4, 4, gl, ga, sc);
    chk("drop_starve_clr", XLEN'(sc), 0);
    chk("drop_ld_wins", XLEN'(gl), 1);

    // asynchronous reset in the middle of a transfer
    @(posedge clk);
    #2;
    alu_valid = 1; alu_rd = 9; alu_result = 99;
    #1;
    rst_n = 1'b0;
    #1;
    q.delete();
    check_zero("midrst");
    @(posedge clk);
    @(posedge clk);
    release_rst();
    @(posedge clk);
    #1;
    chk("post_rst_no_we", XLEN'(rf_we), 0);
    chk("post_rst_starve", XLEN'(starve_cnt), 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) != 0, 5'($urandom), {$urandom, $urandom},
          $urandom_range(0, 3) != 0, 5'($urandom), {$urandom, $urandom},
          gl, ga, sc);
      chk("one_grant", XLEN'(gl & ga), 0);
    end
    cyc(0, 0, 0, 0, 0, 0, gl, ga, sc);
    @(posedge clk);
    #3;
    chk("queue_drained", XLEN'(q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
- REQ-001 SHALL have parameter XLEN, default 64, data width of register-file write data.
- REQ-002 SHALL have parameter STARVE_LIMIT, default 3, consecutive ALU losses before the ALU is forced to win; legal range 1..15.
- REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
- REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
- REQ-005 SHALL have port alu_valid  input  1  ALU result offered for write-back.
- REQ-006 SHALL have port alu_rd  input  5  ALU destination register index.
- REQ-007 SHALL have port alu_result  input  XLEN  ALU result data.
- REQ-008 SHALL have port alu_ready  output  1  ALU offer accepted this cycle.
- REQ-009 SHALL have port ld_valid  input  1  load data returned from memory, offered for write-back.
- REQ-010 SHALL have port ld_rd  input  5  load destination register index.
- REQ-011 SHALL have port ld_data  input  XLEN  load read data.
- REQ-012 SHALL have port ld_ready  output  1  load offer accepted this cycle.
- REQ-013 SHALL have port rf_we  output  1  register-file write enable, registered.
- REQ-014 SHALL have port rf_rd  output  5  register-file write index, registered.
- REQ-015 SHALL have port rf_wdata  output  XLEN  register-file write data, registered.
- REQ-016 SHALL have port rf_src_ld  output  1  registered; 1 = current write came from the load path, 0 = from the ALU path.
- REQ-017 SHALL have port starve_cnt  output  4  current count of consecutive ALU losses, for debug.

Function
- REQ-018 SHALL complete a transfer on a path in any cycle where its valid and ready are both 1; ready SHALL be combinational from the valid inputs and starve_cnt.
- REQ-019 SHALL grant at most one path per cycle; ld_ready and alu_ready SHALL never both be 1.
- REQ-020 SHALL grant a single valid requester unconditionally.
- REQ-021 SHALL grant the load path when both are valid and starve_cnt < STARVE_LIMIT.
- REQ-022 SHALL grant the ALU path when both are valid and starve_cnt == STARVE_LIMIT.
- REQ-023 SHALL drive both readies low when neither valid is 1.
- REQ-024 SHALL update starve_cnt as follows: increment when both are valid and the load wins; clear on an ALU transfer or when alu_valid is 0; otherwise hold; never exceed STARVE_LIMIT.
- REQ-025 SHALL, on the clock edge after a transfer, set rf_rd, rf_wdata and rf_src_ld to the granted path's values, giving a 1-cycle latency.
- REQ-026 SHALL set rf_we to 1 on the clock edge after a transfer only if the granted rd != 0.
- REQ-027 SHALL still accept a transfer to x0 (ready = 1) but suppress it, so rf_we = 0 the next cycle.
- REQ-028 SHALL set rf_we to 0 in any cycle following no transfer, and hold rf_rd, rf_wdata and rf_src_ld at their last values.
- REQ-029 SHALL support back-to-back transfers every cycle with no bubble.
- REQ-030 SHALL NOT require a requester to keep valid high after a loss; a dropped valid carries no state other than starve_cnt per REQ-024.

Reset
- REQ-031 SHALL, while rst_n = 0, immediately force rf_we = 0, rf_rd = 0, rf_wdata = 0, rf_src_ld = 0 and starve_cnt = 0, independent of clk.
- REQ-032 SHALL drive alu_ready = 0 and ld_ready = 0 while rst_n = 0.
- REQ-033 SHALL, if rst_n is asserted mid-operation, discard any transfer in that cycle and produce no write after rst_n is released.
- REQ-034 SHALL allow transfers starting with the first rising clk edge after rst_n is released.

Verification
- REQ-035 SHALL cover: ALU only, alu_valid=1, rd=5, result=42 -> alu_ready=1 the same cycle; the next cycle rf_we=1, rf_rd=5, rf_wdata=42, rf_src_ld=0.
- REQ-036 SHALL cover: both valid for 5 consecutive cycles with STARVE_LIMIT=3 -> grants are L,L,L,A,L and starve_cnt reads 0,1,2,3,0.
- REQ-037 SHALL cover: load with ld_rd=0, ld_data=7 -> ld_ready=1; the next cycle rf_we=0.
- REQ-038 SHALL cover: alternating ALU and load transfers every cycle for 8 cycles -> 8 consecutive rf_we=1 cycles with no bubble, and rf_src_ld alternating.
- REQ-039 SHALL cover: rst_n pulled low between clock edges during a transfer -> outputs zero immediately, no write appears after release, starve_cnt=0.
- REQ-040 SHALL cover: both valid, then alu_valid dropped while starve_cnt=2 -> starve_cnt=0 and the load keeps winning.
